// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences operand pairs into the FP16 MAC datapath, counts
// dot-product elements, clears the accumulator at vector start, and captures
// the normalised result after the fixed datapath latency.
module mac_seq_ctrl #(
   parameter int unsigned VEC_LEN    = 9,
   parameter int unsigned PIPE_LAT   = 2,
   parameter logic [4:0]  Q_FRAC_RST = 5'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_we,
   input  logic [4:0]  cfg_len,
   input  logic [4:0]  cfg_q_frac,
   output logic        cfg_ignored,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_a,
   input  logic [15:0] in_b,
   output logic        mac_en,
   output logic        mac_clr,
   output logic [15:0] mac_a,
   output logic [15:0] mac_b,
   output logic [4:0]  q_frac,
   input  logic [15:0] norm_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        busy
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned LEN_W  = 5;
   localparam int unsigned LAT_W  = $clog2(PIPE_LAT + 1);

   // A zero reset length behaves like a single-element vector.
   localparam logic [LEN_W-1:0] LEN_RST  = (VEC_LEN == 0) ? LEN_W'(1) : LEN_W'(VEC_LEN);
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(PIPE_LAT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DRAIN = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [LEN_W-1:0]    r_cnt,       w_cnt_nxt;
   logic [LAT_W-1:0]    r_lat_cnt,   w_lat_cnt_nxt;
   logic [LEN_W-1:0]    r_len,       w_len_nxt;
   logic [LEN_W-1:0]    r_q_frac,    w_q_frac_nxt;
   logic                r_mac_en,    w_mac_en_nxt;
   logic                r_mac_clr,   w_mac_clr_nxt;
   logic [DATA_W-1:0]   r_mac_a,     w_mac_a_nxt;
   logic [DATA_W-1:0]   r_mac_b,     w_mac_b_nxt;
   logic                r_out_valid, w_out_valid_nxt;
   logic [DATA_W-1:0]   r_out_data,  w_out_data_nxt;
   logic                r_cfg_ign,   w_cfg_ign_nxt;

   logic                w_in_ready;
   logic                w_accept;
   logic [LEN_W-1:0]    w_cfg_len_sat;
   logic [LEN_W-1:0]    w_len_eff;

   // Handshake and effective-length decode.
   always_comb begin
      w_in_ready    = ~rst & ((r_state == S_IDLE) | (r_state == S_ACCUM));
      w_accept      = in_valid & w_in_ready;
      w_cfg_len_sat = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
      // A config write on the starting edge governs the vector it starts.
      w_len_eff     = cfg_we ? w_cfg_len_sat : r_len;
   end

   // Next-state and next-register values.
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_lat_cnt_nxt   = r_lat_cnt;
      w_len_nxt       = r_len;
      w_q_frac_nxt    = r_q_frac;
      w_mac_en_nxt    = 1'b0;
      w_mac_clr_nxt   = 1'b0;
      w_mac_a_nxt     = r_mac_a;
      w_mac_b_nxt     = r_mac_b;
      w_out_valid_nxt = r_out_valid;
      w_out_data_nxt  = r_out_data;
      w_cfg_ign_nxt   = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            if (cfg_we) begin
               w_len_nxt    = w_cfg_len_sat;
               w_q_frac_nxt = cfg_q_frac;
            end
            if (w_accept) begin
               w_mac_en_nxt  = 1'b1;
               w_mac_clr_nxt = 1'b1;
               w_mac_a_nxt   = in_a;
               w_mac_b_nxt   = in_b;
               if (w_len_eff <= LEN_W'(1)) begin
                  w_lat_cnt_nxt = LAT_INIT;
                  w_state_nxt   = S_DRAIN;
               end else begin
                  w_cnt_nxt   = LEN_W'(1);
                  w_state_nxt = S_ACCUM;
               end
            end
         end

         S_ACCUM: begin
            w_cfg_ign_nxt = cfg_we;
            if (w_accept) begin
               w_mac_en_nxt = 1'b1;
               w_mac_a_nxt  = in_a;
               w_mac_b_nxt  = in_b;
               w_cnt_nxt    = r_cnt + LEN_W'(1);
               if (r_cnt == (r_len - LEN_W'(1))) begin
                  w_lat_cnt_nxt = LAT_INIT;
                  w_state_nxt   = S_DRAIN;
               end
            end
         end

         S_DRAIN: begin
            w_cfg_ign_nxt = cfg_we;
            w_lat_cnt_nxt = r_lat_cnt - LAT_W'(1);
            if (r_lat_cnt == LAT_W'(1)) begin
               w_out_data_nxt  = norm_result;
               w_out_valid_nxt = 1'b1;
               w_state_nxt     = S_HOLD;
            end
         end

         S_HOLD: begin
            w_cfg_ign_nxt = cfg_we;
            if (r_out_valid & out_ready) begin
               w_out_valid_nxt = 1'b0;
               w_cnt_nxt       = '0;
               w_state_nxt     = S_IDLE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Counters, configuration and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_lat_cnt   <= '0;
         r_len       <= LEN_RST;
         r_q_frac    <= Q_FRAC_RST;
         r_mac_en    <= 1'b0;
         r_mac_clr   <= 1'b0;
         r_mac_a     <= '0;
         r_mac_b     <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_cfg_ign   <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_lat_cnt   <= w_lat_cnt_nxt;
         r_len       <= w_len_nxt;
         r_q_frac    <= w_q_frac_nxt;
         r_mac_en    <= w_mac_en_nxt;
         r_mac_clr   <= w_mac_clr_nxt;
         r_mac_a     <= w_mac_a_nxt;
         r_mac_b     <= w_mac_b_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_out_data  <= w_out_data_nxt;
         r_cfg_ign   <= w_cfg_ign_nxt;
      end
   end

   assign in_ready    = w_in_ready;
   assign busy        = (r_state != S_IDLE);
   assign cfg_ignored = r_cfg_ign;
   assign mac_en      = r_mac_en;
   assign mac_clr     = r_mac_clr;
   assign mac_a       = r_mac_a;
   assign mac_b       = r_mac_b;
   assign q_frac      = r_q_frac;
   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with default parameters.
module tb_mac_seq_ctrl;

   logic        clk;
   logic        rst;
   logic        cfg_we;
   logic [4:0]  cfg_len;
   logic [4:0]  cfg_q_frac;
   logic        cfg_ignored;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        mac_en;
   logic        mac_clr;
   logic [15:0] mac_a;
   logic [15:0] mac_b;
   logic [4:0]  q_frac;
   logic [15:0] norm_result;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;
   int en_cnt  = 0;

   mac_seq_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we),
      .cfg_len    (cfg_len),
      .cfg_q_frac (cfg_q_frac),
      .cfg_ignored(cfg_ignored),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .mac_en     (mac_en),
      .mac_clr    (mac_clr),
      .mac_a      (mac_a),
      .mac_b      (mac_b),
      .q_frac     (q_frac),
      .norm_result(norm_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge, sample 1 time unit later, tally mac_en pulses.
   task automatic tick();
      @(posedge clk);
      #1;
      if (mac_en === 1'b1) en_cnt++;
   endtask

   task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic exp_clr);
      chk("in_ready_pre", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      tick();
      in_valid = 1'b0;
      chk("mac_en",  32'(mac_en),  32'd1);
      chk("mac_clr", 32'(mac_clr), 32'(exp_clr));
      chk("mac_a",   32'(mac_a),   32'(a));
      chk("mac_b",   32'(mac_b),   32'(b));
   endtask

   // Expects capture two edges after the last accept, handshake on the third.
   task automatic finish_vec(input logic [15:0] exp_data);
      tick();
      chk("ov_early",   32'(out_valid), 32'd0);
      chk("rdy_drain",  32'(in_ready),  32'd0);
      chk("busy_drain", 32'(busy),      32'd1);
      chk("en_drain",   32'(mac_en),    32'd0);
      tick();
      chk("ov_rise",    32'(out_valid), 32'd1);
      chk("out_data",   32'(out_data),  32'(exp_data));
      tick();
      chk("ov_fall",    32'(out_valid), 32'd0);
      chk("rdy_back",   32'(in_ready),  32'd1);
      chk("busy_idle",  32'(busy),      32'd0);
   endtask

   initial begin
      rst         = 1'b1;
      cfg_we      = 1'b0;
      cfg_len     = 5'd0;
      cfg_q_frac  = 5'd0;
      in_valid    = 1'b0;
      in_a        = 16'h0;
      in_b        = 16'h0;
      norm_result = 16'h3C00;
      out_ready   = 1'b1;

      // Reset values
      tick();
      tick();
      chk("rst_in_ready", 32'(in_ready),    32'd0);
      chk("rst_mac_en",   32'(mac_en),      32'd0);
      chk("rst_out_val",  32'(out_valid),   32'd0);
      chk("rst_out_data", 32'(out_data),    32'd0);
      chk("rst_mac_a",    32'(mac_a),       32'd0);
      chk("rst_q_frac",   32'(q_frac),      32'd0);
      chk("rst_busy",     32'(busy),        32'd0);
      chk("rst_cfg_ign",  32'(cfg_ignored), 32'd0);
      rst = 1'b0;
      #1;
      chk("idle_ready", 32'(in_ready), 32'd1);

      // 1: default 9-beat vector, no back-pressure
      en_cnt = 0;
      for (int i = 0; i < 9; i++) beat(16'h1000 + 16'(i), 16'h2000 + 16'(i), i == 0);
      finish_vec(16'h3C00);
      chk("t1_en_cnt", 32'(en_cnt), 32'd9);

      // 2a: configure length 5, q_frac 12
      cfg_we = 1'b1; cfg_len = 5'd5; cfg_q_frac = 5'd12;
      tick();
      cfg_we = 1'b0;
      chk("t2_q_frac", 32'(q_frac),      32'd12);
      chk("t2_no_ign", 32'(cfg_ignored), 32'd0);
      en_cnt = 0;
      norm_result = 16'h4248;
      for (int i = 0; i < 5; i++) beat(16'h3000 + 16'(i), 16'h3100 + 16'(i), i == 0);
      finish_vec(16'h4248);
      chk("t2_en_cnt", 32'(en_cnt), 32'd5);

      // 2b: length 0 written on the same edge as the single beat
      norm_result = 16'h8001;
      cfg_we = 1'b1; cfg_len = 5'd0; cfg_q_frac = 5'd7;
      beat(16'hAAAA, 16'h5555, 1'b1);
      cfg_we = 1'b0;
      chk("t2b_q_frac", 32'(q_frac),   32'd7);
      chk("t2b_drain",  32'(in_ready), 32'd0);
      finish_vec(16'h8001);

      // 3: config write during ACCUM is dropped
      cfg_we = 1'b1; cfg_len = 5'd9; cfg_q_frac = 5'd3;
      tick();
      cfg_we = 1'b0;
      chk("t3_q_frac", 32'(q_frac), 32'd3);
      en_cnt = 0;
      norm_result = 16'h4500;
      beat(16'h0101, 16'h0202, 1'b1);
      beat(16'h0303, 16'h0404, 1'b0);
      cfg_we = 1'b1; cfg_len = 5'd3; cfg_q_frac = 5'd20;
      tick();
      cfg_we = 1'b0;
      chk("t3_ign_pulse", 32'(cfg_ignored), 32'd1);
      chk("t3_q_keep",    32'(q_frac),      32'd3);
      chk("t3_bubble_en", 32'(mac_en),      32'd0);
      tick();
      chk("t3_ign_clear", 32'(cfg_ignored), 32'd0);
      for (int i = 2; i < 9; i++) beat(16'h0500 + 16'(i), 16'h0600 + 16'(i), 1'b0);
      finish_vec(16'h4500);
      chk("t3_en_cnt", 32'(en_cnt), 32'd9);

      // 4: bubbles then 20 cycles of back-pressure
      en_cnt = 0;
      norm_result = 16'h1234;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) beat(16'h7000 + 16'(i), 16'h7100 + 16'(i), i == 0);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("t4_bubble_en",  32'(mac_en),   32'd0);
         chk("t4_bubble_rdy", 32'(in_ready), 32'd1);
      end
      for (int i = 4; i < 9; i++) beat(16'h7000 + 16'(i), 16'h7100 + 16'(i), 1'b0);
      tick();
      chk("t4_ov_early", 32'(out_valid), 32'd0);
      tick();
      chk("t4_ov_rise",  32'(out_valid), 32'd1);
      chk("t4_capture",  32'(out_data),  32'h1234);
      for (int i = 0; i < 20; i++) begin
         norm_result = ~norm_result;
         tick();
         chk("t4_hold_data", 32'(out_data),  32'h1234);
         chk("t4_hold_rdy",  32'(in_ready),  32'd0);
         chk("t4_hold_ov",   32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      tick();
      chk("t4_ov_fall",  32'(out_valid), 32'd0);
      chk("t4_rdy_back", 32'(in_ready),  32'd1);
      chk("t4_en_cnt",   32'(en_cnt),    32'd9);

      // 5: reset after beat 4, then a fresh full vector
      for (int i = 0; i < 4; i++) beat(16'h9000 + 16'(i), 16'h9100 + 16'(i), i == 0);
      rst = 1'b1;
      tick();
      chk("t5_mac_en",   32'(mac_en),      32'd0);
      chk("t5_mac_clr",  32'(mac_clr),     32'd0);
      chk("t5_mac_a",    32'(mac_a),       32'd0);
      chk("t5_mac_b",    32'(mac_b),       32'd0);
      chk("t5_out_val",  32'(out_valid),   32'd0);
      chk("t5_out_data", 32'(out_data),    32'd0);
      chk("t5_q_frac",   32'(q_frac),      32'd0);
      chk("t5_busy",     32'(busy),        32'd0);
      chk("t5_cfg_ign",  32'(cfg_ignored), 32'd0);
      chk("t5_rdy_rst",  32'(in_ready),    32'd0);
      rst = 1'b0;
      #1;
      chk("t5_rdy_idle", 32'(in_ready), 32'd1);
      norm_result = 16'hBEEF;
      en_cnt = 0;
      for (int i = 0; i < 9; i++) beat(16'hC000 + 16'(i), 16'hD000 + 16'(i), i == 0);
      finish_vec(16'hBEEF);
      chk("t5_en_cnt", 32'(en_cnt), 32'd9);

      // 6: reset while a result is held drops out_valid without a handshake
      norm_result = 16'h5A5A;
      out_ready = 1'b0;
      cfg_we = 1'b1; cfg_len = 5'd1; cfg_q_frac = 5'd0;
      beat(16'h0001, 16'h0002, 1'b1);
      cfg_we = 1'b0;
      tick();
      tick();
      chk("t6_ov_held", 32'(out_valid), 32'd1);
      chk("t6_data",    32'(out_data),  32'h5A5A);
      rst = 1'b1;
      tick();
      chk("t6_ov_drop", 32'(out_valid), 32'd0);
      chk("t6_data_rst", 32'(out_data), 32'd0);
      chk("t6_busy",    32'(busy),      32'd0);
      rst = 1'b0;
      out_ready = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
